// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter
// between NUM_REQ message sources. A granted message is latched whole and
// sent one byte at a time over the TxD_start / TxD_busy handshake. Bytes
// from different requesters are never interleaved.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = 5
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*LEN_W-1:0]       req_len_i,
  input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             accept_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           busy_o,
  output logic                           txd_start_o,
  output logic [7:0]                     txd_data_o,
  input  logic                           txd_busy_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MSG_W = MAX_BYTES * 8;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, START, HOLD, FINISH} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [MSG_W-1:0]     data_q, data_d;
  logic [NUM_REQ-1:0]   accept_q, accept_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic [7:0]           txd_data_q, txd_data_d;

  logic                 found;
  logic [IDX_W-1:0]     sel;
  logic [LEN_W-1:0]     sel_len;
  logic [MSG_W-1:0]     sel_data;

  // Round-robin pick: first set request scanning upward from ptr+1 with wrap.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel   = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
    sel_len  = req_len_i[int'(sel)*LEN_W +: LEN_W];
    sel_data = req_data_i[int'(sel)*MSG_W +: MSG_W];
  end

  // Next-state and registered-output decode; outputs take effect on entry.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    accept_d   = '0;
    done_d     = '0;
    start_d    = 1'b0;
    txd_data_d = txd_data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d         = sel;
          ptr_d         = sel;
          len_d         = (sel_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : sel_len;
          data_d        = sel_data;
          accept_d[sel] = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = (len_q == '0) ? FINISH : WAIT_RDY;
      end
      WAIT_RDY: begin
        if (!txd_busy_i) begin
          start_d    = 1'b1;
          txd_data_d = data_q[int'(cnt_q)*8 +: 8];
          state_d    = START;
        end
      end
      START: state_d = HOLD;
      // Guard cycle: the transmitter raises busy one cycle after start.
      HOLD: begin
        cnt_d   = cnt_q + LEN_W'(1);
        state_d = (cnt_q + LEN_W'(1) == len_q) ? FINISH : WAIT_RDY;
      end
      FINISH: begin
        done_d[idx_q] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      len_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      accept_q   <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      txd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      accept_q   <= accept_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      txd_data_q <= txd_data_d;
    end
  end

  assign accept_o    = accept_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign txd_start_o = start_q;
  assign txd_data_o  = txd_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single-requester messages, then
// round-robin contention and reset-mid-message sequences. Sent bytes are
// checked against a scoreboard queue filled when stimulus is driven.
module tb_uart_tx_arbiter;
  localparam int NR = 3;
  localparam int MB = 16;
  localparam int LW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*LW-1:0]  req_len;
  logic [NR*MB*8-1:0] req_data;
  logic [NR-1:0]     accept, done;
  logic              busy, txd_start, txd_busy;
  logic [7:0]        txd_data;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BYTES(MB), .LEN_W(LW)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_len_i(req_len),
    .req_data_i(req_data), .accept_o(accept), .done_o(done), .busy_o(busy),
    .txd_start_o(txd_start), .txd_data_o(txd_data), .txd_busy_i(txd_busy));

  always #5 clk = ~clk;

  // Cycle counter and a simple transmitter model: busy for 4 cycles after start.
  int cyc = 0;
  int bcnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (txd_start) bcnt <= 4;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign txd_busy = (bcnt != 0);

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  int nbytes = 0;
  int acc_cnt = 0;
  int first_start_cyc = 0;
  bit pend_first = 1'b0;
  bit in_msg = 1'b0;
  logic [NR-1:0] cur_idx = '0;

  typedef struct {
    logic [2:0]  req;
    logic [4:0]  len;
    logic [31:0] b;
    logic [2:0]  exp_acc;
    int          nexp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fill_byte(input logic [31:0] b, input int i);
    if (i < 4) return b[i*8 +: 8];
    return 8'(8'h80 + i);
  endfunction

  // Watches the transmit side: byte order, handshake rules, accept/done pairing.
  task automatic monitor();
    bit prev = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_msg = 1'b0;
        prev   = 1'b0;
      end else begin
        if (accept != '0) begin
          acc_cnt++;
          chk("no_interleave", {31'd0, in_msg}, 32'd0);
          cur_idx    = accept;
          in_msg     = 1'b1;
          pend_first = 1'b1;
        end
        if (txd_start) begin
          nbytes++;
          if (pend_first) begin first_start_cyc = cyc; pend_first = 1'b0; end
          chk("start_while_busy", {31'd0, txd_busy}, 32'd0);
          chk("start_one_cycle", {31'd0, prev}, 32'd0);
          if (sb.size() == 0) chk("unexpected_byte", {24'd0, txd_data}, 32'h100);
          else begin
            e = sb.pop_front();
            chk("txd_byte", {24'd0, txd_data}, {24'd0, e});
          end
        end
        if (done != '0) begin
          chk("done_match", {29'd0, done}, {29'd0, cur_idx});
          in_msg = 1'b0;
        end
        prev = txd_start;
      end
    end
  endtask

  task automatic wait_acc(output bit got);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (accept != '0) got = 1'b1;
    end
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (done != '0) got = 1'b1;
    end
  endtask

  task automatic set_msg(input int k, input logic [4:0] len, input logic [31:0] b);
    req_len[k*LW +: LW] = len;
    for (int i = 0; i < MB; i++) req_data[(k*MB+i)*8 +: 8] = fill_byte(b, i);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int k, t0, ta, nb0, a0;
    bit got;
    k = 0;
    for (int i = 0; i < NR; i++) if (v.req[i]) k = i;
    set_msg(k, v.len, v.b);
    for (int i = 0; i < v.nexp; i++) sb.push_back(fill_byte(v.b, i));
    nb0 = nbytes;
    a0  = acc_cnt;
    t0  = cyc;
    req = v.req;
    wait_acc(got);
    req = '0;
    ta  = cyc;
    chk("accept_seen", {31'd0, got}, 32'd1);
    chk("accept_idx", {29'd0, accept}, {29'd0, v.exp_acc});
    chk("accept_latency", ta - t0, 1);
    if (got) begin
      wait_done(got);
      chk("done_seen", {31'd0, got}, 32'd1);
      chk("done_idx", {29'd0, done}, {29'd0, v.exp_acc});
      chk("byte_count", nbytes - nb0, v.nexp);
      chk("sb_empty", sb.size(), 0);
      if (v.nexp == 0) chk("len0_gap", cyc - ta, 2);
      else chk("txd_data_hold", {24'd0, txd_data}, {24'd0, fill_byte(v.b, v.nexp - 1)});
      if (vi == 0) chk("start_latency", first_start_cyc - t0, 3);
      repeat (6) @(negedge clk);
      chk("no_reaccept", acc_cnt - a0, 1);
    end
    sb.delete();
  endtask

  initial begin
    bit got;
    int nb0;
    reset = 1'b1; req = '0; req_len = '0; req_data = '0;
    tbl[0] = '{3'b001, 5'd1,  32'h00000001, 3'b001, 1};
    tbl[1] = '{3'b010, 5'd4,  32'h374F00A2, 3'b010, 4};
    tbl[2] = '{3'b100, 5'd0,  32'hDEADBEEF, 3'b100, 0};
    tbl[3] = '{3'b001, 5'd20, 32'h33221100, 3'b001, 16};
    tbl[4] = '{3'b100, 5'd3,  32'h00C3C2C1, 3'b100, 3};
    tbl[5] = '{3'b010, 5'd16, 32'h5A6B7C8D, 3'b010, 16};
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_accept", {29'd0, accept}, 32'd0);
    chk("rst_done", {29'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, txd_start}, 32'd0);
    chk("rst_data", {24'd0, txd_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Contention straight after reset: grants go 0,1,2,0,1,2.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NR; k++) set_msg(k, 5'd1, 32'h10 + k);
    for (int g = 0; g < 6; g++) sb.push_back(8'(8'h10 + g % 3));
    req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      wait_acc(got);
      if (g == 5) req = '0;
      chk("rr_accept", {29'd0, accept}, 32'd1 << (g % 3));
      wait_done(got);
      chk("rr_done", {29'd0, done}, 32'd1 << (g % 3));
    end
    chk("rr_sb_empty", sb.size(), 0);
    sb.delete();
    repeat (4) @(negedge clk);

    // Reset while the second byte of a 5-byte message is starting.
    set_msg(1, 5'd5, 32'h43424140);
    for (int i = 0; i < 5; i++) sb.push_back(fill_byte(32'h43424140, i));
    nb0 = nbytes;
    req = 3'b010;
    wait_acc(got);
    req = '0;
    chk("mid_accept", {29'd0, accept}, 32'b010);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (txd_start && nbytes - nb0 >= 1 && in_msg && sb.size() <= 4 && nbytes - nb0 == 2) got = 1'b1;
    end
    chk("mid_byte2_seen", {31'd0, got}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_start", {31'd0, txd_start}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    reset = 1'b0;
    set_msg(0, 5'd1, 32'h50);
    set_msg(1, 5'd1, 32'h51);
    sb.push_back(8'h50);
    sb.push_back(8'h51);
    req = 3'b011;
    wait_acc(got);
    chk("post_rst_first", {29'd0, accept}, 32'b001);
    wait_done(got);
    chk("post_rst_done0", {29'd0, done}, 32'b001);
    wait_acc(got);
    req = '0;
    chk("post_rst_second", {29'd0, accept}, 32'b010);
    wait_done(got);
    chk("post_rst_done1", {29'd0, done}, 32'b010);
    chk("post_rst_sb_empty", sb.size(), 0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter (async_transmitter) of top_md5 between several response sources: command ACKs, match-report bytes and the test-pattern generator. Each requester presents a complete message of up to MAX_BYTES bytes. The block grants requesters round-robin, latches the message and sequences it byte-by-byte through the TxD_start/TxD_busy handshake. Messages are atomic: no interleaving of bytes between requesters.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = ack, 1 = match, 2 = test in top_md5)
MAX_BYTES, 16, maximum message length in bytes
LEN_W, 5, width of each length field; must hold MAX_BYTES

Ports:
clk  in  1  system clock (100 MHz in top_md5)
reset  in  1  synchronous, active-high
req  in  NUM_REQ  per-requester message request level
req_len  in  NUM_REQ*LEN_W  per-requester byte count; slice k = [k*LEN_W +: LEN_W]
req_data  in  NUM_REQ*MAX_BYTES*8  per-requester message; slice k byte i = [(k*MAX_BYTES+i)*8 +: 8]
accept  out  NUM_REQ  one-cycle pulse: message k latched, inputs k may change
done  out  NUM_REQ  one-cycle pulse: last byte of message k handed to transmitter
busy  out  1  high whenever state != IDLE
txd_start  out  1  to async_transmitter TxD_start
txd_data  out  8  to async_transmitter TxD_data
txd_busy  in  1  from async_transmitter TxD_busy

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: accept=0, done=0, busy=0, txd_start=0, txd_data=0, state=IDLE, byte counter=0, rr pointer=NUM_REQ-1, so req[0] has top priority after reset.
- All outputs are registered.
- States: IDLE, LOAD, WAIT_RDY, START, HOLD, FINISH.
- IDLE: if any req bit is high, select the first set bit scanning from (ptr+1) mod NUM_REQ upward with wrap. Latch index k, req_len[k] clamped to MAX_BYTES, and the full req_data[k]. Set ptr=k, pulse accept[k], go to LOAD.
- LOAD: counter=0. If latched length is 0, go to FINISH without transmitting. Otherwise go to WAIT_RDY.
- WAIT_RDY: stay while txd_busy=1. When txd_busy=0, go to START.
- START: txd_start=1 for exactly this one cycle. txd_data = latched byte[counter]. Byte 0 (lowest bits) goes first. Go to HOLD.
- HOLD: one guard cycle; txd_busy is ignored because the transmitter raises it one cycle after start. txd_start=0. Increment counter. If counter+1 == length, go to FINISH; else go to WAIT_RDY.
- FINISH: pulse done[k] for one cycle, return to IDLE. The next arbitration happens in IDLE on the following cycle; there is no back-to-back grant in FINISH.
- txd_data holds its last value outside START.
- Minimum latency: req high at edge n → accept at n+1 → txd_start at n+3, given txd_busy=0. Per-byte minimum is 3 cycles plus transmitter busy time.
- Requests and fairness:
  - req is level-sensitive, sampled only in IDLE.
  - Dropping req after accept does not abort the message.
  - Keeping req high after done re-requests, but other pending requesters win first (round-robin).
  - Simultaneous requests: exactly one accept per arbitration. The rest wait, with no loss.
- Boundary conditions:
  - req_len > MAX_BYTES: clamped, exactly MAX_BYTES bytes sent.
  - req_len = 0: accept then done, with 2 cycles between them and no txd_start.
  - Reset mid-message: txd_start deasserts on the next edge and the remaining bytes are discarded. A byte already started completes in the transmitter, and the arbiter ignores it.
- Widths:
  - counter is LEN_W bits wide.
  - The byte mux index is counter*8 within the latched MAX_BYTES*8 vector.

Test Plan:
- Single ack: req=3'b001, len=1, data byte0=8'h01 → accept[0] one cycle later, one txd_start with txd_data=8'h01, done[0] after HOLD; bench async_receiver reads 8'h01.
- Multi-byte: req[1], len=4, bytes 8'hA2,8'h00,8'h4F,8'h37 → exactly 4 txd_start pulses, each only when txd_busy=0, in order A2,00,4F,37; receiver gets the same 4 bytes; done[1] after byte 4 only.
- Contention and round-robin:
  - Stimulus: after reset, all three req held high, each len=1 with distinct bytes 8'h10, 8'h11, 8'h12.
  - Required grant order: 0,1,2,0,...
  - Required response: no byte interleaving; each accept/done pair matches.
- Length edge cases: len=0 → accept and done with no txd_start; len=20 with MAX_BYTES=16 → exactly 16 bytes sent.
- Req dropped after accept: req[2] pulsed one cycle, len=3 → all 3 bytes still sent; no second accept.
- Reset mid-message: assert reset during byte 2 of a 5-byte message → txd_start=0 and busy=0 on the next edge; after release, req[1] and req[0] both high → req[0] granted first.
